// File: rtl/axis_fifo_pkg.sv
// Purpose: shared constants, FSM state type and pointer-width helper for the AXI-Stream packet FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_fifo_pkg;

  localparam int PKT_MODE_WORD  = 0;
  localparam int PKT_MODE_STORE = 1;

  // Packet-mode output gating. STORE releases only complete packets.
  // CUT forwards a packet that cannot fit in the FIFO until its tlast beat leaves.
  typedef enum logic [0:0] {
    PS_STORE = 1'b0,
    PS_CUT   = 1'b1
  } pkt_state_e;

  // The pointers carry one extra wrap bit so that full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Purpose: simple dual-port storage array, DEPTH x WIDTH, with no reset.
// Latency: write is committed on the clk edge; read is combinational from rd_addr.
// Backpressure: none; the caller gates wr_en.
// Ports: clk; wr_en/wr_addr/wr_dat for the write port; rd_addr/rd_dat for the read port.
module axis_fifo_mem #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Purpose: AXI-Stream FIFO with first-word-fall-through output and an optional store-and-forward packet mode.
// Latency: a written word is visible one cycle after its write (word mode); in packet mode, one cycle after the tlast write.
// Backpressure: s_axis_tready drops when full; output is held stable until m_axis_tready accepts it.
// Ports: clk, rst_n (async active-low); s_axis_* slave stream in; m_axis_* master stream out;
//        occupancy, pkt_count (stored entries / complete packets); almost_full, almost_empty threshold flags.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int PKT_MODE   = PKT_MODE_WORD,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  localparam int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [PW-1:0]         occupancy,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PW-1:0]         pkt_count
);

  localparam int            AW   = PW - 1;
  localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              ready_en;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic              wr_last;
  logic              rd_last;
  logic [DATA_WIDTH:0] head;
  pkt_state_e        state;
  pkt_state_e        state_nxt;

  // Entries are stored as {tlast, tdata}.
  axis_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  ({s_axis_tlast, s_axis_tdata}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (head)
  );

  assign m_axis_tlast = head[DATA_WIDTH];
  assign m_axis_tdata = head[DATA_WIDTH-1:0];

  // Same index with a different wrap bit means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign occupancy    = wr_ptr - rd_ptr;
  assign almost_full  = (occupancy >= AF_C);
  assign almost_empty = (occupancy <= AE_C);

  // ready_en holds tready low during reset and releases it on the first edge afterwards.
  assign s_axis_tready = ready_en & ~full;

  assign wr_en   = s_axis_tvalid & s_axis_tready;
  assign rd_en   = m_axis_tvalid & m_axis_tready;
  assign wr_last = wr_en & s_axis_tlast;
  assign rd_last = rd_en & m_axis_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_en  <= 1'b0;
      pkt_count <= '0;
      state     <= PS_STORE;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_last, rd_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // A full FIFO holding no tlast can never complete a packet. Forward that packet
  // rather than deadlock, and keep forwarding until its tlast beat has gone out;
  // otherwise only the first beat would leave and the rest would stall behind
  // the packet-complete gate. The CUT exit is written from tready/empty rather
  // than rd_en so that this block does not read its own m_axis_tvalid output.
  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    if (PKT_MODE == PKT_MODE_WORD) begin
      m_axis_tvalid = ~empty;
    end else begin
      unique case (state)
        PS_STORE: begin
          m_axis_tvalid = (pkt_count != '0) || full;
          if (full && (pkt_count == '0)) begin
            state_nxt = PS_CUT;
          end
        end
        PS_CUT: begin
          m_axis_tvalid = ~empty;
          if (m_axis_tready && !empty && m_axis_tlast) begin
            state_nxt = PS_STORE;
          end
        end
        default: state_nxt = PS_STORE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Purpose: directed and randomized self-checking bench for axis_pkt_fifo (word, packet and DEPTH=8 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_pkt_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  // word-mode instance, DEPTH=4
  logic       w_s_vld = 0, w_s_last = 0, w_m_rdy = 0;
  logic [7:0] w_s_dat = '0;
  logic       w_s_rdy, w_m_vld, w_m_last, w_af, w_ae;
  logic [7:0] w_m_dat;
  logic [2:0] w_occ, w_pkt;

  // packet-mode instance, DEPTH=4
  logic       p_s_vld = 0, p_s_last = 0, p_m_rdy = 0;
  logic [7:0] p_s_dat = '0;
  logic       p_s_rdy, p_m_vld, p_m_last, p_af, p_ae;
  logic [7:0] p_m_dat;
  logic [2:0] p_occ, p_pkt;

  // random-traffic instance, word mode, DEPTH=8
  logic        r_s_vld = 0, r_s_last = 0, r_m_rdy = 0;
  logic [15:0] r_s_dat = '0;
  logic        r_s_rdy, r_m_vld, r_m_last, r_af, r_ae;
  logic [15:0] r_m_dat;
  logic [3:0]  r_occ, r_pkt;

  axis_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(4), .PKT_MODE(0)) u_word (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(w_s_vld), .s_axis_tready(w_s_rdy), .s_axis_tlast(w_s_last), .s_axis_tdata(w_s_dat),
    .m_axis_tvalid(w_m_vld), .m_axis_tready(w_m_rdy), .m_axis_tlast(w_m_last), .m_axis_tdata(w_m_dat),
    .occupancy(w_occ), .almost_full(w_af), .almost_empty(w_ae), .pkt_count(w_pkt)
  );

  axis_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(4), .PKT_MODE(1)) u_pkt (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(p_s_vld), .s_axis_tready(p_s_rdy), .s_axis_tlast(p_s_last), .s_axis_tdata(p_s_dat),
    .m_axis_tvalid(p_m_vld), .m_axis_tready(p_m_rdy), .m_axis_tlast(p_m_last), .m_axis_tdata(p_m_dat),
    .occupancy(p_occ), .almost_full(p_af), .almost_empty(p_ae), .pkt_count(p_pkt)
  );

  axis_pkt_fifo #(.DATA_WIDTH(16), .DEPTH(8), .PKT_MODE(0)) u_rnd (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(r_s_vld), .s_axis_tready(r_s_rdy), .s_axis_tlast(r_s_last), .s_axis_tdata(r_s_dat),
    .m_axis_tvalid(r_m_vld), .m_axis_tready(r_m_rdy), .m_axis_tlast(r_m_last), .m_axis_tdata(r_m_dat),
    .occupancy(r_occ), .almost_full(r_af), .almost_empty(r_ae), .pkt_count(r_pkt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  bit wr, rd;
  int n_sent = 0;
  int n_rcv  = 0;
  int cyc    = 0;

  initial begin
    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #2;
    chk("rst_w_s_rdy", 32'(w_s_rdy), 0);
    chk("rst_w_m_vld", 32'(w_m_vld), 0);
    chk("rst_w_occ",   32'(w_occ),   0);
    chk("rst_w_ae",    32'(w_ae),    1);
    chk("rst_w_af",    32'(w_af),    0);
    chk("rst_w_pkt",   32'(w_pkt),   0);
    chk("rst_p_m_vld", 32'(p_m_vld), 0);
    chk("rst_p_s_rdy", 32'(p_s_rdy), 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(w_s_rdy), 0);
    step();
    chk("rdy_after_edge_w", 32'(w_s_rdy), 1);
    chk("rdy_after_edge_p", 32'(p_s_rdy), 1);

    // ---------------- word mode: fill to full, then drain ----------------
    for (int i = 0; i < 4; i++) begin
      w_s_vld = 1'b1;
      w_s_dat = 8'(8'hA0 + i);
      step();
      chk("w_fill_occ",  32'(w_occ),   i + 1);
      chk("w_fill_vld",  32'(w_m_vld), 1);
      chk("w_fill_head", 32'(w_m_dat), 32'hA0);
      chk("w_fill_af",   32'(w_af),    (i >= 1) ? 1 : 0);
      chk("w_fill_ae",   32'(w_ae),    (i <= 1) ? 1 : 0);
    end
    w_s_vld = 1'b0;
    chk("w_full_rdy", 32'(w_s_rdy), 0);
    chk("w_full_occ", 32'(w_occ),   4);
    w_m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("w_drain_vld",  32'(w_m_vld),  1);
      chk("w_drain_dat",  32'(w_m_dat),  32'hA0 + i);
      chk("w_drain_last", 32'(w_m_last), 0);
      step();
    end
    w_m_rdy = 1'b0;
    chk("w_empty_occ", 32'(w_occ),   0);
    chk("w_empty_vld", 32'(w_m_vld), 0);
    chk("w_empty_rdy", 32'(w_s_rdy), 1);
    chk("w_empty_ae",  32'(w_ae),    1);

    // ---------------- word mode: streaming at occupancy 2 ----------------
    for (int i = 0; i < 2; i++) begin
      w_s_vld = 1'b1;
      w_s_dat = 8'(8'hB0 + i);
      step();
    end
    w_m_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w_s_dat = 8'(8'hB2 + i);
      chk("w_stream_vld", 32'(w_m_vld), 1);
      chk("w_stream_dat", 32'(w_m_dat), 32'hB0 + i);
      step();
      chk("w_stream_occ", 32'(w_occ), 2);
    end
    w_s_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("w_tail_dat", 32'(w_m_dat), 32'hBA + i);
      step();
    end
    w_m_rdy = 1'b0;
    chk("w_tail_occ", 32'(w_occ), 0);
    chk("w_tail_pkt", 32'(w_pkt), 0);

    // ---------------- packet mode: held until tlast ----------------
    for (int i = 0; i < 3; i++) begin
      chk("p_hold_vld", 32'(p_m_vld), 0);
      p_s_vld  = 1'b1;
      p_s_last = (i == 2);
      p_s_dat  = 8'(8'hC0 + i);
      step();
    end
    p_s_vld  = 1'b0;
    p_s_last = 1'b0;
    chk("p_rel_vld", 32'(p_m_vld), 1);
    chk("p_rel_pkt", 32'(p_pkt),   1);
    chk("p_rel_dat", 32'(p_m_dat), 32'hC0);
    p_m_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("p_drain_dat",  32'(p_m_dat),  32'hC0 + i);
      chk("p_drain_last", 32'(p_m_last), (i == 2) ? 1 : 0);
      step();
    end
    p_m_rdy = 1'b0;
    chk("p_drain_pkt", 32'(p_pkt),   0);
    chk("p_drain_vld", 32'(p_m_vld), 0);

    // ---------------- packet mode: oversize packet fallback ----------------
    for (int i = 0; i < 4; i++) begin
      p_s_vld = 1'b1;
      p_s_dat = 8'(8'hD0 + i);
      step();
      if (i < 3) chk("p_ovf_hold_vld", 32'(p_m_vld), 0);
    end
    p_s_vld = 1'b0;
    chk("p_ovf_occ", 32'(p_occ),   4);
    chk("p_ovf_pkt", 32'(p_pkt),   0);
    chk("p_ovf_vld", 32'(p_m_vld), 1);
    chk("p_ovf_rdy", 32'(p_s_rdy), 0);
    p_m_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("p_ovf_drain_vld", 32'(p_m_vld), 1);
      chk("p_ovf_drain_dat", 32'(p_m_dat), 32'hD0 + i);
      step();
    end
    p_m_rdy = 1'b0;
    chk("p_ovf_empty_vld", 32'(p_m_vld), 0);
    chk("p_ovf_empty_occ", 32'(p_occ),   0);
    // tail of the oversize packet is forwarded as soon as it arrives
    p_s_vld  = 1'b1;
    p_s_last = 1'b1;
    p_s_dat  = 8'hD4;
    step();
    p_s_vld  = 1'b0;
    p_s_last = 1'b0;
    chk("p_ovf_tail_vld",  32'(p_m_vld),  1);
    chk("p_ovf_tail_last", 32'(p_m_last), 1);
    chk("p_ovf_tail_dat",  32'(p_m_dat),  32'hD4);
    p_m_rdy = 1'b1;
    step();
    p_m_rdy = 1'b0;
    chk("p_ovf_done_pkt", 32'(p_pkt), 0);

    // ---------------- reset mid-packet ----------------
    for (int i = 0; i < 3; i++) begin
      p_s_vld = 1'b1;
      p_s_dat = 8'(8'hE0 + i);
      step();
      chk("p_mid_vld", 32'(p_m_vld), 0);
    end
    p_s_vld = 1'b0;
    chk("p_mid_occ", 32'(p_occ), 3);
    rst_n = 1'b0;
    #1;
    chk("p_rst_vld", 32'(p_m_vld), 0);
    chk("p_rst_occ", 32'(p_occ),   0);
    chk("p_rst_pkt", 32'(p_pkt),   0);
    chk("p_rst_rdy", 32'(p_s_rdy), 0);
    chk("p_rst_ae",  32'(p_ae),    1);
    step();
    rst_n = 1'b1;
    step();
    chk("p_rerdy", 32'(p_s_rdy), 1);
    for (int i = 0; i < 2; i++) begin
      p_s_vld  = 1'b1;
      p_s_last = (i == 1);
      p_s_dat  = 8'(8'hF0 + i);
      step();
    end
    p_s_vld  = 1'b0;
    p_s_last = 1'b0;
    chk("p_post_pkt", 32'(p_pkt),   1);
    chk("p_post_occ", 32'(p_occ),   2);
    chk("p_post_vld", 32'(p_m_vld), 1);
    p_m_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("p_post_dat",  32'(p_m_dat),  32'hF0 + i);
      chk("p_post_last", 32'(p_m_last), i);
      step();
    end
    p_m_rdy = 1'b0;
    chk("p_post_empty", 32'(p_m_vld), 0);

    // ---------------- random traffic, DEPTH=8 ----------------
    while (n_rcv < 1000 && cyc < 20000) begin
      r_s_vld = (n_sent < 1000) && ($urandom_range(0, 1) == 1);
      r_s_dat = 16'(n_sent);
      r_m_rdy = ($urandom_range(0, 1) == 1);
      chk("rnd_occ", 32'(r_occ),   n_sent - n_rcv);
      chk("rnd_vld", 32'(r_m_vld), (n_sent != n_rcv) ? 1 : 0);
      wr = r_s_vld && r_s_rdy;
      rd = r_m_vld && r_m_rdy;
      if (rd) chk("rnd_data", 32'(r_m_dat), 32'(16'(n_rcv)));
      step();
      cyc++;
      if (wr) n_sent++;
      if (rd) n_rcv++;
    end
    r_s_vld = 1'b0;
    r_m_rdy = 1'b0;
    chk("rnd_done",  n_rcv, 1000);
    chk("rnd_occ0",  32'(r_occ),    0);
    chk("rnd_ae",    32'(r_ae),     1);
    chk("rnd_af",    32'(r_af),     0);
    chk("rnd_pkt",   32'(r_pkt),    0);
    chk("rnd_last",  32'(r_m_last) & 32'(r_m_vld), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
